// File: rtl/pixie_pkg.sv
// Shared types and constants for the pixie memory arbiter and its I/O decode.
package pixie_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXferCpu,
        StXferVid
    } arb_state_e;

    localparam logic [7:0] OOR_CPU_DATA = 8'hFF;
    localparam logic [7:0] OOR_VID_DATA = 8'h00;

    // 17-bit compare so a window ending at 64K neither wraps nor aliases.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                       input int unsigned aw);
        logic [16:0] a;
        logic [16:0] lo;
        logic [16:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (17'd1 << aw);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/pixie_io_decode.sv
// Decodes CPU INP/OUT strobes on the display port into disp_on/disp_off pulses and disp_en.
module pixie_io_decode #(
    parameter logic [2:0] DISP_PORT = 3'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_strobe,
    input  logic       io_inp,
    input  logic       io_out,
    input  logic [2:0] io_n,
    output logic       disp_on,
    output logic       disp_off,
    output logic       disp_en
);

    logic hit;
    logic disp_on_q, disp_off_q, disp_en_q;

    assign hit = io_strobe && (io_n == DISP_PORT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_on_q  <= 1'b0;
            disp_off_q <= 1'b0;
            disp_en_q  <= 1'b0;
        end else begin
            // With both INP and OUT set, off takes precedence.
            disp_on_q  <= hit && io_inp && !io_out;
            disp_off_q <= hit && io_out;
            if (hit && io_out) begin
                disp_en_q <= 1'b0;
            end else if (hit && io_inp) begin
                disp_en_q <= 1'b1;
            end
        end
    end

    assign disp_on  = disp_on_q;
    assign disp_off = disp_off_q;
    assign disp_en  = disp_en_q;

endmodule

// File: rtl/pixie_mem_arbiter.sv
// Shares the single-port RAM between the CDP1802 CPU and pixie video fetch, video first but
// bounded by a run limit; also hosts the display on/off I/O decode.
module pixie_mem_arbiter
    import pixie_pkg::*;
#(
    parameter int unsigned RAM_AW      = 9,
    parameter logic [15:0] RAM_BASE    = 16'h0800,
    parameter int unsigned MAX_VID_RUN = 8,
    parameter logic [2:0]  DISP_PORT   = 3'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [15:0]       vid_addr,
    output logic [7:0]        vid_rdata,
    output logic              vid_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              io_strobe,
    input  logic              io_inp,
    input  logic              io_out,
    input  logic [2:0]        io_n,
    output logic              disp_on,
    output logic              disp_off,
    output logic              disp_en
);

    localparam int unsigned       RUN_W   = $clog2(MAX_VID_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_VID_RUN);

    arb_state_e       state_q;
    logic [RUN_W-1:0] run_q;
    logic             in_range_q;

    logic cpu_in_range, vid_in_range;
    logic grant_cpu, grant_vid;

    assign cpu_in_range = in_window(cpu_addr, RAM_BASE, RAM_AW);
    assign vid_in_range = in_window(vid_addr, RAM_BASE, RAM_AW);

    // Grants only in IDLE and never while reset is high, so reset kills ram_we at once.
    always_comb begin
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        if ((state_q == StIdle) && !reset) begin
            if (vid_req && (!cpu_req || (run_q != RUN_MAX))) begin
                grant_vid = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (grant_vid) begin
            ram_addr = vid_addr[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
        end else if (grant_cpu) begin
            ram_addr = cpu_addr[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
            if (cpu_we && cpu_in_range) begin
                ram_we    = 1'b1;
                ram_wdata = cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            run_q      <= '0;
            in_range_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vid) begin
                        state_q    <= StXferVid;
                        in_range_q <= vid_in_range;
                    end else if (grant_cpu) begin
                        state_q    <= StXferCpu;
                        in_range_q <= cpu_in_range;
                    end
                    if (grant_cpu || !cpu_req) begin
                        run_q <= '0;
                    end else if (grant_vid && (run_q != RUN_MAX)) begin
                        run_q <= run_q + RUN_W'(1);
                    end
                end
                StXferCpu, StXferVid: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // RAM read data arrives in the XFER cycle, so acks and rdata decode from the state.
    assign cpu_ack   = (state_q == StXferCpu);
    assign vid_ack   = (state_q == StXferVid);
    assign cpu_rdata = cpu_ack ? (in_range_q ? ram_rdata : OOR_CPU_DATA) : 8'h00;
    assign vid_rdata = vid_ack ? (in_range_q ? ram_rdata : OOR_VID_DATA) : 8'h00;

    pixie_io_decode #(
        .DISP_PORT(DISP_PORT)
    ) u_io_decode (
        .clk      (clk),
        .reset    (reset),
        .io_strobe(io_strobe),
        .io_inp   (io_inp),
        .io_out   (io_out),
        .io_n     (io_n),
        .disp_on  (disp_on),
        .disp_off (disp_off),
        .disp_en  (disp_en)
    );

endmodule

// File: tb/tb_pixie_mem_arbiter.sv
// Directed bench for pixie_mem_arbiter with a behavioural 512-byte synchronous RAM.
module tb_pixie_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = 16'h0000;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        io_strobe = 1'b0, io_inp = 1'b0, io_out = 1'b0;
    logic [2:0]  io_n = 3'd0;
    logic        disp_on, disp_off, disp_en;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [512];

    // Results of the last cpu_xfer call.
    logic [7:0] x_rdata;
    int         x_cycles;
    logic       x_got;
    int         x_we_cnt;
    logic [8:0] x_we_addr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    pixie_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_strobe(io_strobe), .io_inp(io_inp), .io_out(io_out), .io_n(io_n),
        .disp_on(disp_on), .disp_off(disp_off), .disp_en(disp_en)
    );

    // One CPU access from IDLE; x_cycles counts clock edges from request to ack.
    task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        x_got = 1'b0; x_cycles = 0; x_we_cnt = 0; x_we_addr = '0; x_rdata = 8'h00;
        while (!x_got && x_cycles < 40) begin
            #1;
            if (ram_we) begin x_we_cnt++; x_we_addr = ram_addr; end
            @(posedge clk); #1; x_cycles++;
            if (cpu_ack) begin x_got = 1'b1; x_rdata = cpu_rdata; end
            @(negedge clk);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0805; cpu_wdata = 8'h33; vid_req = 1'b1;
        #1;
        n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_vec++; if (ram_addr !== 9'h000) begin n_err++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
        @(posedge clk); #1;
        n_vec++; if ({cpu_ack, vid_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b want 00", {cpu_ack, vid_ack}); end
        n_vec++; if ({disp_on, disp_off, disp_en} !== 3'b000) begin n_err++; $display("FAIL reset_disp: got %b want 000", {disp_on, disp_off, disp_en}); end
        n_vec++; if ({cpu_rdata, vid_rdata} !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", {cpu_rdata, vid_rdata}); end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        cpu_xfer(1'b1, 16'h0805, 8'h5A);
        n_vec++; if (x_got !== 1'b1) begin n_err++; $display("FAIL rmw_setup_ack: got %b want 1", x_got); end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0805; cpu_wdata = 8'hC3;
        #1;
        n_vec++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rmw_grant_we: got %b want 1", ram_we); end
        reset = 1'b1; #1;
        n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rmw_we_drop: got %b want 0", ram_we); end
        @(posedge clk); #1;
        n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rmw_no_ack: got %b want 0", cpu_ack); end
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rmw_no_late_ack: got %b want 0", cpu_ack); end
        cpu_xfer(1'b0, 16'h0805, 8'h00);
        n_vec++; if (x_rdata !== 8'h5A) begin n_err++; $display("FAIL rmw_byte_kept: got %h want 5a", x_rdata); end
    endtask

    task automatic test_write_read();
        cpu_xfer(1'b1, 16'h0810, 8'hA5);
        n_vec++; if (x_we_cnt !== 1) begin n_err++; $display("FAIL wr_we_cycles: got %0d want 1", x_we_cnt); end
        n_vec++; if (x_we_addr !== 9'h010) begin n_err++; $display("FAIL wr_ram_addr: got %h want 010", x_we_addr); end
        n_vec++; if (x_got !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b want 1", x_got); end
        cpu_xfer(1'b0, 16'h0810, 8'h00);
        // Grant cycle plus transfer cycle: ack on the first edge after the request.
        n_vec++; if (x_cycles !== 1) begin n_err++; $display("FAIL rd_latency: got %0d want 1", x_cycles); end
        n_vec++; if (x_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", x_rdata); end
        n_vec++; if (x_we_cnt !== 0) begin n_err++; $display("FAIL rd_no_we: got %0d want 0", x_we_cnt); end
    endtask

    task automatic test_out_of_range();
        cpu_xfer(1'b0, 16'h0000, 8'h00);
        n_vec++; if (x_rdata !== 8'hFF) begin n_err++; $display("FAIL oor_rd_data: got %h want ff", x_rdata); end
        n_vec++; if (x_we_cnt !== 0) begin n_err++; $display("FAIL oor_rd_we: got %0d want 0", x_we_cnt); end
        n_vec++; if (x_cycles !== 1) begin n_err++; $display("FAIL oor_rd_latency: got %0d want 1", x_cycles); end
        cpu_xfer(1'b1, 16'h0800, 8'h11);
        cpu_xfer(1'b1, 16'h0A00, 8'h99);
        n_vec++; if (x_we_cnt !== 0) begin n_err++; $display("FAIL oor_wr_0a00_we: got %0d want 0", x_we_cnt); end
        n_vec++; if (x_got !== 1'b1) begin n_err++; $display("FAIL oor_wr_ack: got %b want 1", x_got); end
        cpu_xfer(1'b1, 16'h07FF, 8'h88);
        n_vec++; if (x_we_cnt !== 0) begin n_err++; $display("FAIL oor_wr_07ff_we: got %0d want 0", x_we_cnt); end
        cpu_xfer(1'b0, 16'h0800, 8'h00);
        n_vec++; if (x_rdata !== 8'h11) begin n_err++; $display("FAIL oor_no_alias: got %h want 11", x_rdata); end
        cpu_xfer(1'b1, 16'h09FF, 8'h77);
        n_vec++; if (x_we_addr !== 9'h1FF) begin n_err++; $display("FAIL top_byte_addr: got %h want 1ff", x_we_addr); end
        cpu_xfer(1'b0, 16'h09FF, 8'h00);
        n_vec++; if (x_rdata !== 8'h77) begin n_err++; $display("FAIL top_byte_data: got %h want 77", x_rdata); end
        // Out-of-range video fetch.
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0000;
        x_got = 1'b0; x_cycles = 0;
        while (!x_got && x_cycles < 40) begin
            @(posedge clk); #1; x_cycles++;
            if (vid_ack) begin x_got = 1'b1; x_rdata = vid_rdata; end
        end
        @(negedge clk); vid_req = 1'b0;
        n_vec++; if (x_got !== 1'b1) begin n_err++; $display("FAIL oor_vid_ack: got %b want 1", x_got); end
        n_vec++; if (x_rdata !== 8'h00) begin n_err++; $display("FAIL oor_vid_data: got %h want 00", x_rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_vid_priority();
        logic [9:0] seq;
        int n_ack, cyc, cpu_wait, both;
        logic [7:0] first_vid, cpu_dat;
        seq = '0; n_ack = 0; cyc = 0; cpu_wait = -1; both = 0;
        first_vid = 8'h00; cpu_dat = 8'h00;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h0810;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0805;
        while (n_ack < 10 && cyc < 80) begin
            @(posedge clk); #1; cyc++;
            if (cpu_ack && vid_ack) both++;
            if (vid_ack) begin
                if (n_ack == 0) first_vid = vid_rdata;
                n_ack++;
            end else if (cpu_ack) begin
                seq[n_ack] = 1'b1; cpu_wait = cyc; cpu_dat = cpu_rdata; n_ack++;
                @(negedge clk); cpu_req = 1'b0;
            end
        end
        @(negedge clk); vid_req = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (n_ack !== 10) begin n_err++; $display("FAIL prio_ack_count: got %0d want 10", n_ack); end
        n_vec++; if (seq !== 10'b01_0000_0000) begin n_err++; $display("FAIL prio_order: got %b want 0100000000", seq); end
        n_vec++; if (!(cpu_wait >= 1 && cpu_wait <= 18)) begin n_err++; $display("FAIL prio_cpu_wait: got %0d want 1..18", cpu_wait); end
        n_vec++; if (cpu_dat !== 8'h5A) begin n_err++; $display("FAIL prio_cpu_data: got %h want 5a", cpu_dat); end
        n_vec++; if (first_vid !== 8'hA5) begin n_err++; $display("FAIL prio_vid_data: got %h want a5", first_vid); end
        n_vec++; if (both !== 0) begin n_err++; $display("FAIL prio_dual_ack: got %0d want 0", both); end
    endtask

    task automatic test_display();
        @(negedge clk);
        io_strobe = 1'b1; io_inp = 1'b1; io_out = 1'b0; io_n = 3'd1;
        #1;
        n_vec++; if (disp_on !== 1'b0) begin n_err++; $display("FAIL disp_on_early: got %b want 0", disp_on); end
        @(posedge clk); #1;
        n_vec++; if ({disp_on, disp_off, disp_en} !== 3'b101) begin n_err++; $display("FAIL disp_on_pulse: got %b want 101", {disp_on, disp_off, disp_en}); end
        @(negedge clk); io_strobe = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({disp_on, disp_en} !== 2'b01) begin n_err++; $display("FAIL disp_on_one_cycle: got %b want 01", {disp_on, disp_en}); end
        @(negedge clk); io_strobe = 1'b1; io_inp = 1'b0; io_out = 1'b1; io_n = 3'd2;
        @(posedge clk); #1;
        n_vec++; if ({disp_on, disp_off, disp_en} !== 3'b001) begin n_err++; $display("FAIL disp_wrong_port: got %b want 001", {disp_on, disp_off, disp_en}); end
        @(negedge clk); io_n = 3'd1;
        @(posedge clk); #1;
        n_vec++; if ({disp_on, disp_off, disp_en} !== 3'b010) begin n_err++; $display("FAIL disp_off_pulse: got %b want 010", {disp_on, disp_off, disp_en}); end
        @(negedge clk); io_inp = 1'b1; io_out = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); io_inp = 1'b1; io_out = 1'b1;
        @(posedge clk); #1;
        n_vec++; if ({disp_on, disp_off, disp_en} !== 3'b010) begin n_err++; $display("FAIL disp_both_off_wins: got %b want 010", {disp_on, disp_off, disp_en}); end
        @(negedge clk); io_strobe = 1'b0; io_inp = 1'b0; io_out = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({disp_on, disp_off} !== 2'b00) begin n_err++; $display("FAIL disp_idle: got %b want 00", {disp_on, disp_off}); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_write_read();
        test_out_of_range();
        test_vid_priority();
        test_display();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
